// File: rtl/ysyx_23060303_defs.sv
// Shared definitions for the instruction fetch stage.
package ysyx_23060303_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060303_fetch_fifo.sv
// Small synchronous FIFO with flush and registered head outputs.
module ysyx_23060303_fetch_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             head_valid_q, head_valid_d;
   logic [WIDTH-1:0] head_data_q, head_data_d;
   logic             do_push, do_pop;

   // Next storage/pointer state; the head is precomputed so out_* come straight from flops.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q < CW'(DEPTH)) || do_pop);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
      head_valid_d = (cnt_d != '0);
      head_data_d  = mem_d[rd_d];
   end

   // FIFO state registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

   assign count      = cnt_q;
   assign head_valid = head_valid_q;
   assign head_data  = head_data_q;

endmodule

// File: rtl/ysyx_23060303_ifu_fetch.sv
// Instruction fetch: PC register, one-outstanding memory request FSM, output FIFO.
//
// state   | meaning
// IDLE    | no request outstanding; waiting for FIFO space, halt low, no redirect
// REQ     | imem_req_valid high with a stable address until imem_req_ready
// WAIT    | request accepted; waiting for imem_rsp_valid
module ysyx_23060303_ifu_fetch
   import ysyx_23060303_defs::*;
#(
   parameter int                 PCWIDTH    = 32,
   parameter logic [PCWIDTH-1:0] RESET_PC   = PCWIDTH'(DEF_RESET_PC),
   parameter int                 FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [PCWIDTH-1:0] redirect_pc,
   input  logic               halt,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PCWIDTH-1:0] imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [31:0]        imem_rsp_data,
   input  logic               imem_rsp_err,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PCWIDTH-1:0] out_pc,
   output logic [31:0]        out_inst,
   output logic               out_err
);

   localparam int EW = PCWIDTH + 33;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e       state_q, state_d;
   logic [PCWIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PCWIDTH-1:0] req_addr_q, req_addr_d;
   logic               drop_q, drop_d;

   logic [CW-1:0]      fifo_count, count_next;
   logic               head_valid;
   logic [EW-1:0]      head_data;
   logic               pop, rsp_take, push, can_issue;
   logic               unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign pop      = head_valid && out_ready;
   assign rsp_take = (state_q == ST_WAIT) && imem_rsp_valid;
   assign push     = rsp_take && !drop_q && !redirect_valid;
   // Occupancy after this cycle's pop and push; counting the push keeps a
   // request from being issued when its response would have nowhere to go.
   assign count_next = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));
   assign can_issue  = !halt && !redirect_valid && (count_next < CW'(FIFO_DEPTH));

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         drop_q     <= drop_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (can_issue) state_d = ST_REQ;
         ST_REQ:  if (imem_req_ready) state_d = ST_WAIT;
         ST_WAIT: if (imem_rsp_valid) state_d = can_issue ? ST_REQ : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // PC advance, redirect, drop tracking and request address latch.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      req_addr_d = req_addr_q;
      if (push) begin
         fetch_pc_d = fetch_pc_q + PCWIDTH'(4);
      end
      if (rsp_take) begin
         drop_d = 1'b0;
      end
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[PCWIDTH-1:2], 2'b00};
         // A request still in flight must have its response discarded.
         if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !imem_rsp_valid)) begin
            drop_d = 1'b1;
         end
      end
      // Address is frozen for the whole REQ phase, even across a redirect.
      if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
         req_addr_d = fetch_pc_d;
      end
   end

   // FSM outputs.
   always_comb begin
      imem_req_valid = (state_q == ST_REQ);
      imem_req_addr  = req_addr_q;
   end

   ysyx_23060303_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  ({fetch_pc_q, imem_rsp_data, imem_rsp_err}),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (fifo_count),
      .head_valid (head_valid),
      .head_data  (head_data)
   );

   assign out_valid = head_valid;
   assign out_pc    = head_data[EW-1:33];
   assign out_inst  = head_data[32:1];
   assign out_err   = head_data[0];

endmodule

// File: tb/tb_ysyx_23060303_ifu_fetch.sv
// Scoreboard bench for the fetch stage: directed scenarios, memory model, output monitor.
module tb_ysyx_23060303_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_err;

   always #5 clk = ~clk;

   ysyx_23060303_ifu_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_err        (out_err)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_req = 0;
   logic [31:0] last_req = '0;
   int          rsp_delay = 1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %b, required %b", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst, input logic err);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Memory: accepts a request, answers rsp_delay cycles later with {C0DE, addr[15:0]}.
   initial begin : mem_model
      bit          pend;
      int          cd;
      logic [31:0] pa;
      pend = 0;
      cd   = 0;
      pa   = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pend = 0;
         end else if (!pend && imem_req_valid && imem_req_ready) begin
            pend = 1;
            pa   = imem_req_addr;
            cd   = rsp_delay;
         end
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_err   = 1'b0;
         if (!rst) begin
            pend = 0;
         end else if (pend) begin
            if (cd <= 1) begin
               pend           = 0;
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = {16'hC0DE, pa[15:0]};
               imem_rsp_err   = (pa == err_addr);
            end else begin
               cd--;
            end
         end
      end
   end

   // Monitor: counts request handshakes and checks every consumed output entry.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && imem_req_valid && imem_req_ready) begin
            n_req++;
            last_req = imem_req_addr;
         end
         if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_unexpected: actual pc %h, required no entry", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc", out_pc, e.pc);
               chk("out_inst", out_inst, e.inst);
               chk1("out_err", out_err, e.err);
            end
         end
      end
   end

   task automatic wait_req(input int n);
      int b;
      b = 0;
      while (n_req < n && b < 200) begin
         @(posedge clk);
         b++;
      end
      if (n_req < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_req: actual %0d requests, required %0d", n_req, n);
      end
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 200) begin
         @(posedge clk);
         b++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
      end
      #1 out_ready = 1'b0;
   endtask

   // Holds reset for three edges, checks reset outputs, then releases into cycle 1.
   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_inst", out_inst, 32'h0);
      chk1("rst_out_err", out_err, 1'b0);
      exp_q.delete();
      n_req = 0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin : stimulus
      // Sequential fetch, zero-wait memory: requests in cycles 2, 4, 6.
      do_reset();
      rsp_delay = 1;
      out_ready = 1'b1;
      exp_push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      exp_push(32'h8000_0004, 32'hC0DE_0004, 1'b0);
      exp_push(32'h8000_0008, 32'hC0DE_0008, 1'b0);
      @(negedge clk); chk1("t1_c1_req_valid", imem_req_valid, 1'b0);
      @(negedge clk); chk1("t1_c2_req_valid", imem_req_valid, 1'b1);
      chk("t1_c2_req_addr", imem_req_addr, 32'h8000_0000);
      @(negedge clk); chk1("t1_c3_req_valid", imem_req_valid, 1'b0);
      @(negedge clk); chk1("t1_c4_req_valid", imem_req_valid, 1'b1);
      chk("t1_c4_req_addr", imem_req_addr, 32'h8000_0004);
      @(negedge clk); chk1("t1_c5_req_valid", imem_req_valid, 1'b0);
      @(negedge clk); chk1("t1_c6_req_valid", imem_req_valid, 1'b1);
      chk("t1_c6_req_addr", imem_req_addr, 32'h8000_0008);
      drain();

      // Backpressure: two entries fill the FIFO, fetching stops, resumes at 8000_0008.
      do_reset();
      repeat (12) @(posedge clk);
      chk("t2_req_count", n_req, 32'd2);
      @(negedge clk);
      chk1("t2_req_valid_idle", imem_req_valid, 1'b0);
      chk1("t2_out_valid_full", out_valid, 1'b1);
      exp_push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      exp_push(32'h8000_0004, 32'hC0DE_0004, 1'b0);
      exp_push(32'h8000_0008, 32'hC0DE_0008, 1'b0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_req(3);
      chk("t2_resume_addr", last_req, 32'h8000_0008);
      drain();

      // Redirect during WAIT with a buffered entry: flush and drop the in-flight response.
      do_reset();
      rsp_delay = 3;
      wait_req(2);
      #1;
      chk1("t3_pre_out_valid", out_valid, 1'b1);
      chk("t3_pre_out_pc", out_pc, 32'h8000_0000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk1("t3_flushed_out_valid", out_valid, 1'b0);
      exp_push(32'h8000_0100, 32'hC0DE_0100, 1'b0);
      out_ready = 1'b1;
      wait_req(3);
      chk("t3_redirect_addr", last_req, 32'h8000_0100);
      drain();

      // Redirect coinciding with a response and an output handshake.
      do_reset();
      rsp_delay = 1;
      exp_push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      wait_req(2);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      out_ready      = 1'b1;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      @(negedge clk);
      chk1("t4_out_valid_after", out_valid, 1'b0);
      chk("t4_consumed_once", exp_q.size(), 32'd0);
      exp_push(32'h8000_0200, 32'hC0DE_0200, 1'b0);
      out_ready = 1'b1;
      wait_req(3);
      chk("t4_redirect_addr", last_req, 32'h8000_0200);
      drain();

      // Halt during WAIT: response still delivered, no new request until release.
      do_reset();
      rsp_delay = 3;
      out_ready = 1'b1;
      exp_push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      wait_req(1);
      #1 halt = 1'b1;
      repeat (12) @(posedge clk);
      chk("t5_halt_req_count", n_req, 32'd1);
      @(negedge clk);
      chk1("t5_halt_req_valid", imem_req_valid, 1'b0);
      chk("t5_halt_delivered", exp_q.size(), 32'd0);
      out_ready = 1'b0;
      halt      = 1'b0;
      wait_req(2);
      chk("t5_resume_addr", last_req, 32'h8000_0004);

      // Access fault passes through on one entry only.
      do_reset();
      rsp_delay = 1;
      err_addr  = 32'h8000_0004;
      out_ready = 1'b1;
      exp_push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      exp_push(32'h8000_0004, 32'hC0DE_0004, 1'b1);
      exp_push(32'h8000_0008, 32'hC0DE_0008, 1'b0);
      drain();
      err_addr = 32'hFFFF_FFFF;

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: actual still running, required finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ysyx_23060303_ifu_fetch.md
# ysyx_23060303_ifu_fetch

Instruction fetch stage with a real memory handshake. It sits directly upstream of the decode/execute datapath. It owns the PC and issues one-at-a-time read requests to instruction memory over a valid/ready bus. Returned words go into a small FIFO, which presents {pc, inst, err} to the IDU through a valid/ready interface. It accepts PC redirects from the EXU, flushing buffered and in-flight instructions, and honours a halt input that stops fetching after an ebreak.

## Interface
- PCWIDTH, 32, width of PC and memory address
- RESET_PC, 32'h8000_0000, first fetch address after reset
- FIFO_DEPTH, 2, fetched-instruction buffer entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the next rising clk edge)
- redirect_valid  in  1  one-cycle PC redirect pulse from EXU
- redirect_pc  in  PCWIDTH  redirect target; bits [1:0] ignored (forced 00)
- halt  in  1  level; while 1, no new requests are issued
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PCWIDTH  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid (one pulse per accepted request)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- out_valid  out  1  FIFO head valid
- out_ready  in  1  IDU consumes head
- out_pc  out  PCWIDTH  PC of head instruction
- out_inst  out  32  head instruction
- out_err  out  1  head carries access fault

## Operation
- State machine IDLE, REQ, WAIT. At most one request is outstanding.
- IDLE → REQ when halt==0, redirect_valid==0, and FIFO count (after this cycle's pop) < FIFO_DEPTH.
- REQ: imem_req_valid=1, imem_req_addr=fetch_pc. Once asserted, valid and addr stay stable until imem_req_ready. On handshake → WAIT.
- WAIT, on imem_rsp_valid:
  - if drop==0: push {fetch_pc, data, err} and fetch_pc += 4 (wraps mod 2^PCWIDTH).
  - next state is REQ if the issue condition holds, else IDLE.
- Redirect:
  - fetch_pc ← {redirect_pc[PCWIDTH-1:2], 2'b00}.
  - FIFO flushed; a same-cycle push is suppressed.
  - Redirect in REQ (with or without handshake) or in WAIT sets drop=1. The pending request completes and its response is discarded, then drop clears. A response arriving in the redirect cycle itself is discarded.
  - Redirect in IDLE only updates fetch_pc.
- A pop in the redirect cycle counts as consumed. The flush removes the remaining entries.
- Halt: completes any outstanding request and buffers its response. No further REQ entry until halt==0. A redirect during halt still updates fetch_pc and flushes.
- imem_rsp_err entries are passed through unmodified. The fetch unit keeps fetching sequentially.

## Timing
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, drop=0, FIFO empty.
  - imem_req_valid=0, out_valid=0, out_pc=0, out_inst=0, out_err=0.
- First imem_req_valid is asserted in the 2nd cycle after rst rises (IDLE→REQ).
- FIFO outputs are registered. An entry pushed in cycle N is visible on out_* in cycle N+1.
- Best-case throughput: one instruction per 2 cycles (REQ with ready, then WAIT with rsp).
- Simultaneous push and pop on a full FIFO is allowed. The issue condition uses the post-pop count.
- Reset asserted mid-transaction abandons all state. The memory model must also be reset; no response is expected afterwards.

## Structure
- Shared package/header ysyx_23060303_defs holds:
  - FSM state encoding (2 bits)
  - RESET_PC default
  - EBREAK encoding 32'h0010_0073
  - NOP 32'h0000_0013
- Sub-module ysyx_23060303_fetch_fifo: parameterised sync FIFO with push, pop, flush, count, and registered head outputs.
- Top-level glue is the FSM plus the PC register.

## Test plan
- Reset release, memory with zero-wait ready and 1-cycle response → requests to 8000_0000, 8000_0004, 8000_0008 in cycles 2, 4, 6; out_pc follows in order.
- out_ready=0 with FIFO_DEPTH=2 → exactly 2 entries buffered, imem_req_valid stays 0. Raising out_ready resumes fetching at 8000_0008.
- Redirect to 8000_0103 while in WAIT → response discarded, FIFO emptied, next request at 8000_0100, next out_pc=8000_0100.
- Redirect in the same cycle as imem_rsp_valid and an out handshake → popped entry consumed once, response dropped, out_valid=0 next cycle.
- halt=1 during WAIT → response buffered, no new request for 10 cycles. halt=0 → request at the next sequential PC.
- imem_rsp_err=1 on 8000_0004 → out_err=1 with out_pc=8000_0004; the next entry at 8000_0008 has out_err=0.
